// File: rtl/i2c_master_arbiter_pkg.sv
// Shared definitions for the i2c_master round-robin arbiter: FSM encoding and
// command-byte field constants.
package i2c_master_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StWaitBusy = 2'd1,
        StRunning  = 2'd2,
        StDone     = 2'd3
    } arb_state_e;

    localparam int unsigned I2C_RW_BIT = 0;
    localparam logic        I2C_READ   = 1'b1;
    localparam logic        I2C_WRITE  = 1'b0;

endpackage

// File: rtl/i2c_master_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping
// modulo N_REQ. Outputs a one-hot winner and its index.
module i2c_master_arbiter_rr_arbiter #(
    parameter int unsigned N_REQ = 2
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic [N_REQ-1:0]         win_oh,
    output logic [$clog2(N_REQ)-1:0] win_idx
);

    localparam int unsigned IW = $clog2(N_REQ);

    always_comb begin
        logic [IW-1:0] idx;
        win_oh  = '0;
        win_idx = '0;
        idx     = '0;
        // Scan from farthest to nearest so the requester closest to ptr wins.
        for (int off = int'(N_REQ) - 1; off >= 0; off--) begin
            idx = IW'((32'(ptr) + 32'(off)) % N_REQ);
            if (req[idx]) begin
                win_oh      = '0;
                win_oh[idx] = 1'b1;
                win_idx     = idx;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sharing of one i2c_master among N_REQ requesters.
// Optional transaction timeout abort enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter
    import i2c_master_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned TIMEOUT_CLKS = 4096
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_cmd,
    input  logic [8*N_REQ-1:0] req_wdata,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic [7:0]         rdata,
    output logic               rdata_vld,
    output logic               err,
    output logic               idle,
    output logic               m_en,
    output logic [7:0]         m_cmd,
    output logic [7:0]         m_wdata,
    input  logic               m_busy,
    input  logic               m_data_rdy,
    input  logic [7:0]         m_rdata
);

    localparam int unsigned IW = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d, win_oh;
    logic [IW-1:0]    ptr_q, ptr_d, widx_q, widx_d, win_idx;
    logic [7:0]       rdata_q, rdata_d, hold_q, hold_d;
    logic [7:0]       m_cmd_q, m_cmd_d, m_wdata_q, m_wdata_d;
    logic             rdata_vld_q, rdata_vld_d, err_q, err_d;
    logic             m_en_q, m_en_d, idle_q, idle_d;
    logic             is_read, timeout;

    i2c_master_arbiter_rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_rr (
        .req     (req),
        .ptr     (ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    assign is_read = (m_cmd_q[I2C_RW_BIT] != I2C_WRITE);

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int unsigned CW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    logic [CW-1:0] cnt_q, cnt_d;

    // Held at zero in IDLE so it is clear on entry to WAIT_BUSY.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end else if (state_q == StWaitBusy || state_q == StRunning) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign timeout = (state_q == StWaitBusy || state_q == StRunning) &&
                     (cnt_q == CW'(TIMEOUT_CLKS - 1));
`else
    logic unused_timeout_clks;
    assign unused_timeout_clks = ^TIMEOUT_CLKS;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:     if (|req) state_d = StWaitBusy;
            StWaitBusy: begin
                if (timeout)     state_d = StDone;
                else if (m_busy) state_d = StRunning;
            end
            StRunning:  if (timeout || !m_busy) state_d = StDone;
            StDone:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    always_comb begin
        gnt_d       = gnt_q;
        done_d      = '0;
        rdata_d     = rdata_q;
        rdata_vld_d = 1'b0;
        err_d       = 1'b0;
        m_en_d      = m_en_q;
        m_cmd_d     = m_cmd_q;
        m_wdata_d   = m_wdata_q;
        ptr_d       = ptr_q;
        widx_d      = widx_q;
        hold_d      = hold_q;
        idle_d      = (state_d == StIdle);

        if (state_q == StIdle && |req) begin
            gnt_d     = win_oh;
            widx_d    = win_idx;
            m_cmd_d   = req_cmd[{win_idx, 3'b000} +: 8];
            m_wdata_d = req_wdata[{win_idx, 3'b000} +: 8];
            m_en_d    = 1'b1;
        end
        if (state_q == StWaitBusy && (timeout || m_busy)) m_en_d = 1'b0;
        if (state_q == StRunning && m_data_rdy && m_cmd_q[I2C_RW_BIT] == I2C_READ) begin
            hold_d = m_rdata;
        end
        // Completion outputs are registered on the edge entering DONE.
        if (state_q != StDone && state_d == StDone) begin
            done_d      = gnt_q;
            err_d       = timeout;
            rdata_vld_d = is_read && !timeout;
            if (is_read && !timeout) rdata_d = hold_d;
        end
        if (state_q == StDone) begin
            gnt_d = '0;
            ptr_d = (widx_q == IW'(N_REQ - 1)) ? '0 : widx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            rdata_vld_q <= 1'b0;
            err_q       <= 1'b0;
            m_en_q      <= 1'b0;
            m_cmd_q     <= '0;
            m_wdata_q   <= '0;
            idle_q      <= 1'b1;
            ptr_q       <= '0;
            widx_q      <= '0;
            hold_q      <= '0;
        end else begin
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            rdata_q     <= rdata_d;
            rdata_vld_q <= rdata_vld_d;
            err_q       <= err_d;
            m_en_q      <= m_en_d;
            m_cmd_q     <= m_cmd_d;
            m_wdata_q   <= m_wdata_d;
            idle_q      <= idle_d;
            ptr_q       <= ptr_d;
            widx_q      <= widx_d;
            hold_q      <= hold_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign rdata     = rdata_q;
    assign rdata_vld = rdata_vld_q;
    assign err       = err_q;
    assign idle      = idle_q;
    assign m_en      = m_en_q;
    assign m_cmd     = m_cmd_q;
    assign m_wdata   = m_wdata_q;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Scoreboard bench for i2c_master_arbiter with a behavioural i2c_master model.
module tb_i2c_master_arbiter;

    localparam int unsigned N = 2;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, gnt, done;
    logic [8*N-1:0] req_cmd, req_wdata;
    logic [7:0]     rdata, m_cmd, m_wdata, m_rdata;
    logic           rdata_vld, err, idle, m_en, m_busy, m_data_rdy;

    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         g_cyc = 0;
    int         busy_len = 20;
    int         bcnt;
    logic       never_busy = 1'b0;
    logic       mon_en = 1'b0;
    logic [7:0] mst_rdata = 8'h00;
    logic [7:0] last_rd = 8'h00;

    typedef struct {
        logic [N-1:0] done;
        logic [7:0]   cmd;
        logic [7:0]   wdata;
        logic [7:0]   rdata;
        logic         vld;
        logic         err;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    i2c_master_arbiter #(
        .N_REQ        (N),
        .TIMEOUT_CLKS (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_cmd    (req_cmd),
        .req_wdata  (req_wdata),
        .gnt        (gnt),
        .done       (done),
        .rdata      (rdata),
        .rdata_vld  (rdata_vld),
        .err        (err),
        .idle       (idle),
        .m_en       (m_en),
        .m_cmd      (m_cmd),
        .m_wdata    (m_wdata),
        .m_busy     (m_busy),
        .m_data_rdy (m_data_rdy),
        .m_rdata    (m_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural master: busy for busy_len cycles after en, data_rdy near the end of reads.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy     <= 1'b0;
            m_data_rdy <= 1'b0;
            m_rdata    <= 8'h00;
            bcnt       <= 0;
        end else begin
            m_data_rdy <= 1'b0;
            if (!m_busy) begin
                if (m_en && !never_busy && bcnt == 0) begin
                    m_busy <= 1'b1;
                    bcnt   <= busy_len;
                end
            end else begin
                bcnt <= bcnt - 1;
                if (bcnt == 2 && m_cmd[0]) begin
                    m_data_rdy <= 1'b1;
                    m_rdata    <= mst_rdata;
                end
                if (bcnt == 1) m_busy <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_txn(input int idx, input logic [7:0] cmd, input logic [7:0] wdata,
                              input logic [7:0] rd, input logic to_err);
        exp_t e;
        if (cmd[0] && !to_err) last_rd = rd;
        e.done  = N'(1) << idx;
        e.cmd   = cmd;
        e.wdata = wdata;
        e.rdata = last_rd;
        e.vld   = cmd[0] && !to_err;
        e.err   = to_err;
        sb.push_back(e);
    endtask

    task automatic wait_done(input logic [N-1:0] mask, input int limit, input logic clr);
        int n;
        n = 0;
        @(negedge clk);
        while ((done & mask) == 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if ((done & mask) == 0) check("done_wait_expired", 32'(done), 32'(mask));
        if (clr) req = req & ~mask;
    endtask

    always @(negedge clk) begin
        if (!rst && mon_en) begin
            check("stray_pulse", {30'd0, rdata_vld && done == 0, err && done == 0}, 32'd0);
            if (done != 0) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("done_vec", 32'(done), 32'(mon_e.done));
                    check("m_cmd", 32'(m_cmd), 32'(mon_e.cmd));
                    check("m_wdata", 32'(m_wdata), 32'(mon_e.wdata));
                    check("rdata_vld", 32'(rdata_vld), 32'(mon_e.vld));
                    check("err", 32'(err), 32'(mon_e.err));
                    check("rdata", 32'(rdata), 32'(mon_e.rdata));
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = '0; req_cmd = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_m_en", 32'(m_en), 32'd0);
        check("rst_m_cmd", 32'(m_cmd), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Single write from requester 0
        req_cmd[7:0] = 8'hAA; req_wdata[7:0] = 8'h3C;
        expect_txn(0, 8'hAA, 8'h3C, 8'h00, 1'b0);
        req[0] = 1'b1;
        @(negedge clk);
        check("wr_m_en_latency", 32'(m_en), 32'd1);
        check("wr_gnt", 32'(gnt), 32'd1);
        check("wr_idle", 32'(idle), 32'd0);
        wait_done(2'b01, 100, 1'b1);
        repeat (2) @(negedge clk);

        // Single read from requester 1
        req_cmd[15:8] = 8'hEF; req_wdata[15:8] = 8'h11; mst_rdata = 8'h5A;
        expect_txn(1, 8'hEF, 8'h11, 8'h5A, 1'b0);
        req[1] = 1'b1;
        @(negedge clk);
        check("rd_gnt", 32'(gnt), 32'd2);
        wait_done(2'b10, 100, 1'b1);
        repeat (2) @(negedge clk);

        // Write must leave rdata at the last read value
        req_cmd[7:0] = 8'h40; req_wdata[7:0] = 8'h99; mst_rdata = 8'hFF;
        expect_txn(0, 8'h40, 8'h99, 8'h00, 1'b0);
        req[0] = 1'b1;
        wait_done(2'b01, 100, 1'b1);
        repeat (2) @(negedge clk);

        // Contention from reset: order 0,1,0,1
        rst = 1'b1;
        @(negedge clk);
        check("rst2_rdata", 32'(rdata), 32'd0);
        rst = 1'b0;
        last_rd = 8'h00;
        req_cmd = {8'h20, 8'h10}; req_wdata = {8'hB2, 8'hB1};
        for (int k = 0; k < 2; k++) begin
            expect_txn(0, 8'h10, 8'hB1, 8'h00, 1'b0);
            expect_txn(1, 8'h20, 8'hB2, 8'h00, 1'b0);
        end
        req = 2'b11;
        @(negedge clk);
        check("cont_first_gnt", 32'(gnt), 32'd1);
        repeat (3) wait_done(2'b11, 100, 1'b0);
        wait_done(2'b11, 100, 1'b1);
        repeat (2) @(negedge clk);

        // Latching: cmd/wdata changes after grant are ignored
        req_cmd[7:0] = 8'hAA; req_wdata[7:0] = 8'h3C;
        expect_txn(0, 8'hAA, 8'h3C, 8'h00, 1'b0);
        req[0] = 1'b1;
        @(negedge clk);
        check("latch_gnt", 32'(gnt), 32'd1);
        repeat (2) @(negedge clk);
        req_cmd[7:0] = 8'h00; req_wdata[7:0] = 8'h00;
        repeat (3) @(negedge clk);
        check("latch_m_cmd", 32'(m_cmd), 32'hAA);
        wait_done(2'b01, 100, 1'b1);
        repeat (2) @(negedge clk);

        // Reset mid-RUNNING with pointer at 1
        req_cmd[15:8] = 8'hEF; mst_rdata = 8'hC3;
        req[1] = 1'b1;
        @(negedge clk);
        check("mid_gnt", 32'(gnt), 32'd2);
        repeat (5) @(negedge clk);
        check("mid_running_busy", 32'(m_busy), 32'd1);
        check("mid_running_m_en", 32'(m_en), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("async_gnt", 32'(gnt), 32'd0);
        check("async_m_en", 32'(m_en), 32'd0);
        check("async_m_cmd", 32'(m_cmd), 32'd0);
        check("async_m_wdata", 32'(m_wdata), 32'd0);
        check("async_idle", 32'(idle), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 8'h00;
        req_cmd[7:0] = 8'h5C; req_wdata[7:0] = 8'h01;
        expect_txn(0, 8'h5C, 8'h01, 8'h00, 1'b0);
        expect_txn(1, 8'hEF, req_wdata[15:8], 8'hC3, 1'b0);
        req = 2'b11;
        @(negedge clk);
        check("post_rst_first_gnt", 32'(gnt), 32'd1);
        wait_done(2'b01, 100, 1'b1);
        wait_done(2'b10, 100, 1'b1);
        repeat (2) @(negedge clk);

`ifdef I2C_ARB_TIMEOUT_EN
        // Master never asserts busy: abort after 16 cycles
        never_busy = 1'b1;
        req_cmd[7:0] = 8'h30; req_wdata[7:0] = 8'h44;
        expect_txn(0, 8'h30, 8'h44, 8'h00, 1'b1);
        req[0] = 1'b1;
        @(negedge clk);
        check("to_gnt", 32'(gnt), 32'd1);
        g_cyc = cyc;
        wait_done(2'b01, 100, 1'b1);
        check("to_latency", 32'(cyc - g_cyc), 32'd16);
        check("to_m_en", 32'(m_en), 32'd0);
        @(negedge clk);
        check("to_idle", 32'(idle), 32'd1);
        never_busy = 1'b0;
        repeat (2) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
